mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- sequencing controller for an external multi-cycle multiplier core.
//
// Accepts 64x64 operand pairs, registers them toward the core, runs a
// START/BUSY/CLEAR handshake with the core, and queues the 128-bit products in
// a small circular FIFO for downstream. An operation that sees no op_done within
// TIMEOUT busy cycles is aborted with a one-cycle timeout_err pulse.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid/in_a/in_b    upstream operand pair; in_ready accepts it
//   op_start, op_clear    commands to the multiplier core
//   mul_a, mul_b          registered operands to the core
//   op_done, mul_result   core completion flag and product
//   out_valid/out_data    FIFO head; popped when out_ready=1
//   busy                  controller is not idle
//   timeout_err           one-cycle pulse when an operation is aborted
module mul_seq_ctrl #(
  parameter int OUT_DEPTH = 2,
  parameter int TIMEOUT   = 100
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [63:0]  in_a,
  input  logic [63:0]  in_b,
  output logic         in_ready,
  output logic         op_start,
  output logic         op_clear,
  output logic [63:0]  mul_a,
  output logic [63:0]  mul_b,
  input  logic         op_done,
  input  logic [127:0] mul_result,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         timeout_err
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [9:0]       TMO_LAST = 10'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         wait_cnt_q, wait_cnt_d;
  logic [63:0]        mul_a_q, mul_a_d;
  logic [63:0]        mul_b_q, mul_b_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout_err_q, timeout_err_d;
  logic               op_start_q, op_start_d;
  logic               op_clear_q, op_clear_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               push_s;
  logic               pop_s;
  logic [127:0]       fifo_mem_q [OUT_DEPTH];

  // Circular pointer advance, wrapping from the last slot back to slot 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Next-state logic for the operation sequencer and operand registers.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    push_s        = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        wait_cnt_d = 10'd0;
        // in_ready_q is only ever set while idle with room in the FIFO.
        if (in_valid && in_ready_q) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        wait_cnt_d = 10'd0;
        state_d    = BUSY;
      end
      BUSY: begin
        // op_done has priority over a timeout landing on the same cycle.
        if (op_done) begin
          push_s  = 1'b1;
          state_d = CLEAR;
        end else if (wait_cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = CLEAR;
        end else begin
          wait_cnt_d = wait_cnt_q + 10'd1;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer/count update; a push can only happen with a free slot because
  // a new operation is only accepted while the FIFO is not full.
  always_comb begin
    pop_s    = out_valid_q && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output flags are decoded from next state so they leave straight from flops.
  always_comb begin
    op_start_d  = (state_d == START) || (state_d == BUSY);
    op_clear_d  = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == IDLE) && (count_d < DEPTH_C);
    out_valid_d = (count_d != '0);
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= 10'd0;
      mul_a_q       <= 64'd0;
      mul_b_q       <= 64'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timeout_err_q <= 1'b0;
      op_start_q    <= 1'b0;
      op_clear_q    <= 1'b0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timeout_err_q <= timeout_err_d;
      op_start_q    <= op_start_d;
      op_clear_q    <= op_clear_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Result storage; contents are not reset, validity comes from count_q.
  always_ff @(posedge clk) begin
    if (reset_n && push_s) begin
      fifo_mem_q[wr_ptr_q] <= mul_result;
    end
  end

  assign in_ready    = in_ready_q;
  assign op_start    = op_start_q;
  assign op_clear    = op_clear_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = out_valid_q;
  assign out_data    = fifo_mem_q[rd_ptr_q];
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (OUT_DEPTH=2, TIMEOUT=100).
// The bench plays the multiplier core: it raises op_done with a hand-computed
// product after a chosen number of BUSY cycles.
module tb_mul_seq_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [63:0]  in_a;
  logic [63:0]  in_b;
  logic         in_ready;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  mul_a;
  logic [63:0]  mul_b;
  logic         op_done;
  logic [127:0] mul_result;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int tmo_pulses = 0;

  mul_seq_ctrl #(.OUT_DEPTH(2), .TIMEOUT(100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_ready    (in_ready),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .op_done     (op_done),
    .mul_result  (mul_result),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Count timeout pulses; sampled on the falling edge so each pulse counts once.
  always @(negedge clk) begin
    if (timeout_err === 1'b1) tmo_pulses <= tmo_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op_start"}, op_start, 1'b0);
    check_eq({tag, "_op_clear"}, op_clear, 1'b0);
    check_eq({tag, "_mul_a"}, mul_a, 64'd0);
    check_eq({tag, "_mul_b"}, mul_b, 64'd0);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  // Offer an operand pair and wait (bounded) for it to be taken.
  task automatic do_accept(input logic [63:0] a, input logic [63:0] b);
    int waited;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    check_eq("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_eq("accept_op_start", op_start, 1'b1);
    check_eq("accept_mul_a", mul_a, a);
    check_eq("accept_mul_b", mul_b, b);
    check_eq("accept_busy", busy, 1'b1);
  endtask

  // Called in START: n BUSY cycles without op_done, then op_done with res.
  task automatic run_core(input int n, input logic [127:0] res, input logic pop);
    step();
    repeat (n) step();
    check_eq("busy_op_start", op_start, 1'b1);
    check_eq("busy_op_clear", op_clear, 1'b0);
    op_done    = 1'b1;
    mul_result = res;
    out_ready  = pop;
    step();
    op_done    = 1'b0;
    mul_result = 128'd0;
    out_ready  = 1'b0;
    check_eq("clear_op_clear", op_clear, 1'b1);
    check_eq("clear_op_start", op_start, 1'b0);
    check_eq("clear_timeout_err", timeout_err, 1'b0);
    check_eq("clear_out_valid", out_valid, 1'b1);
  endtask

  task automatic back_to_idle();
    step();
    check_eq("idle_op_clear", op_clear, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  task automatic pop_check(input logic [127:0] exp);
    check_eq("pop_valid", out_valid, 1'b1);
    check_eq("pop_data", out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_a       = 64'd0;
    in_b       = 64'd0;
    op_done    = 1'b0;
    mul_result = 128'd0;
    out_ready  = 1'b0;

    // Reset state.
    @(negedge clk);
    step();
    step();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    step();
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_reset_outputs("post_rst");

    // op_done in IDLE is ignored.
    op_done    = 1'b1;
    mul_result = 128'd99;
    step();
    op_done    = 1'b0;
    check_eq("idle_done_out_valid", out_valid, 1'b0);
    check_eq("idle_done_busy", busy, 1'b0);

    // 3 x 5 = 15, op_done after 66 BUSY cycles.
    do_accept(64'd3, 64'd5);
    run_core(66, 128'd15, 1'b0);
    check_eq("r42_data", out_data, 128'd15);
    back_to_idle();
    check_eq("r42_hold_a", mul_a, 64'd3);
    pop_check(128'd15);
    check_eq("r42_empty", out_valid, 1'b0);

    // Backpressure: 2x7, 4x4 fill the FIFO, 9x9 waits.
    do_accept(64'd2, 64'd7);
    run_core(5, 128'd14, 1'b0);
    back_to_idle();
    check_eq("bp_ready_after_1", in_ready, 1'b1);
    do_accept(64'd4, 64'd4);
    run_core(8, 128'd16, 1'b0);
    back_to_idle();
    check_eq("bp_full_ready", in_ready, 1'b0);
    check_eq("bp_head", out_data, 128'd14);
    in_valid = 1'b1;
    in_a     = 64'd9;
    in_b     = 64'd9;
    step();
    step();
    check_eq("bp_no_accept_busy", busy, 1'b0);
    check_eq("bp_no_accept_a", mul_a, 64'd4);
    pop_check(128'd14);
    check_eq("bp_ready_after_pop", in_ready, 1'b1);
    do_accept(64'd9, 64'd9);
    check_eq("bp_head_16", out_data, 128'd16);
    run_core(10, 128'd81, 1'b0);
    back_to_idle();
    pop_check(128'd16);
    pop_check(128'd81);
    check_eq("bp_empty", out_valid, 1'b0);

    // Timeout: no op_done at all.
    do_accept(64'd11, 64'd13);
    step();
    repeat (99) step();
    check_eq("tmo_not_yet", timeout_err, 1'b0);
    check_eq("tmo_still_busy", busy, 1'b1);
    step();
    check_eq("tmo_pulse", timeout_err, 1'b1);
    check_eq("tmo_op_clear", op_clear, 1'b1);
    check_eq("tmo_no_push", out_valid, 1'b0);
    step();
    check_eq("tmo_pulse_end", timeout_err, 1'b0);
    check_eq("tmo_idle", busy, 1'b0);
    check_eq("tmo_ready", in_ready, 1'b1);
    check_eq("tmo_pulse_count", tmo_pulses, 1);

    // op_done on the final timeout count wins; full 128-bit product.
    do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    run_core(99, 128'h1_FFFF_FFFF_FFFF_FFFE, 1'b0);
    check_eq("race_data", out_data, 128'h1_FFFF_FFFF_FFFF_FFFE);
    back_to_idle();
    check_eq("race_no_tmo", tmo_pulses, 1);
    pop_check(128'h1_FFFF_FFFF_FFFF_FFFE);

    // Reset at BUSY cycle 20 abandons the operation.
    do_accept(64'd6, 64'd7);
    step();
    repeat (20) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_reset_outputs("midrst");
    check_eq("midrst_in_ready", in_ready, 1'b1);
    repeat (3) step();
    check_eq("midrst_no_result", out_valid, 1'b0);
    do_accept(64'd8, 64'd8);
    run_core(3, 128'd64, 1'b0);
    check_eq("midrst_new_data", out_data, 128'd64);
    back_to_idle();
    pop_check(128'd64);

    // Push and pop on the same edge with one entry queued.
    do_accept(64'd10, 64'd10);
    run_core(4, 128'd100, 1'b0);
    back_to_idle();
    do_accept(64'd20, 64'd10);
    run_core(4, 128'd200, 1'b1);
    check_eq("pp_data_advanced", out_data, 128'd200);
    back_to_idle();
    pop_check(128'd200);
    check_eq("pp_count_was_one", out_valid, 1'b0);
    check_eq("final_tmo_count", tmo_pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
